// File: rtl/pll_seq_pkg.sv
// Shared types, 50 MHz default timings and helpers for the PLL reset sequencer.
// Imported by pll_reset_sequencer.

package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } seq_state_e;

    localparam int unsigned PLL_RST_CYCLES_50M   = 16;
    localparam int unsigned LOCK_TIMEOUT_1MS_50M = 50000;
    localparam int unsigned STABLE_1K            = 1024;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst_n;
        logic ready;
        logic fault;
    } seq_out_t;

    // Width of the shared cycle counter: enough for the longest programmed interval.
    function automatic int unsigned cycle_cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic seq_out_t decode_state(input seq_state_e s);
        seq_out_t o;
        o.pll_rst   = (s == PLL_RESET) || (s == FAIL);
        o.sys_rst_n = (s == RUN);
        o.ready     = (s == RUN);
        o.fault     = (s == FAIL);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, asynchronous active-low reset to zero.
// Each bit is synchronized independently; use only for level signals.

module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset from refclk and releases the system reset once lock has been stable.
// Optional retry limit with FAIL state: define PLL_SEQ_RETRY_LIMIT_EN.

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_50M,
    parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_1MS_50M,
    parameter int unsigned STABLE_CYCLES  = STABLE_1K,
    parameter int unsigned MAX_RETRIES    = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             i_refclk,
    input  logic             i_rst_n,
    input  logic             i_pll_locked,
    output logic             o_pll_rst,
    output logic             o_sys_rst_n,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_lock_loss_cnt,
    output logic             o_fault
);

    localparam int unsigned CYC_W = cycle_cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Transitions fire on the last counted cycle, so compare against N-1.
    localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    logic             w_locked_s;
    seq_state_e       r_state;
    seq_state_e       w_state_next;
    seq_out_t         w_out_next;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_loss_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_ready;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk   (i_refclk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_locked),
        .o_q     (w_locked_s)
    );

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_fault;
    logic               w_retry_exhausted;

    assign w_retry_exhausted = (32'(r_retry_cnt) + 32'd1) >= MAX_RETRIES;
`else
    logic w_unused;

    assign w_unused = ^{w_out_next.fault, MAX_RETRIES};
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PLL_RESET: begin
                if (r_cyc_cnt == RST_LAST) w_state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (w_locked_s) begin
                    w_state_next = STABLE;
                end else if (r_cyc_cnt == TIMEOUT_LAST) begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                    w_state_next = w_retry_exhausted ? FAIL : PLL_RESET;
`else
                    w_state_next = PLL_RESET;
`endif
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_cyc_cnt == STABLE_LAST) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!w_locked_s) w_state_next = WAIT_LOCK;
            end
            FAIL: begin
                w_state_next = FAIL;
            end
            default: begin
                w_state_next = PLL_RESET;
            end
        endcase
    end

    assign w_out_next = decode_state(w_state_next);

    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= PLL_RESET;
            r_cyc_cnt   <= '0;
            r_loss_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            r_retry_cnt <= '0;
            r_fault     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_pll_rst   <= w_out_next.pll_rst;
            r_sys_rst_n <= w_out_next.sys_rst_n;
            r_ready     <= w_out_next.ready;

            // RUN and FAIL are untimed, so the counter parks there.
            if (w_state_next != r_state) begin
                r_cyc_cnt <= '0;
            end else if (r_state inside {PLL_RESET, WAIT_LOCK, STABLE}) begin
                r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
            end

            if (r_state == RUN && !w_locked_s && r_loss_cnt != LOSS_MAX) begin
                r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
            r_fault <= w_out_next.fault;
            if (r_state == WAIT_LOCK && w_state_next == PLL_RESET) begin
                r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
            end else if (r_state != RUN && w_state_next == RUN) begin
                r_retry_cnt <= '0;
            end
`endif
        end
    end

    assign o_pll_rst       = r_pll_rst;
    assign o_sys_rst_n     = r_sys_rst_n;
    assign o_ready         = r_ready;
    assign o_lock_loss_cnt = r_loss_cnt;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    assign o_fault         = r_fault;
`else
    assign o_fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed vectors, corner sequences and
// random lock activity against a behavioural model.

module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int CNT_W          = 2;
    localparam int LOSS_SAT       = (1 << CNT_W) - 1;

    localparam int MD_PULSE  = 0;
    localparam int MD_WAIT   = 1;
    localparam int MD_STABLE = 2;
    localparam int MD_RUN    = 3;
    localparam int MD_FAIL   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] lock_loss_cnt;

    int edge_n;
    int n_checks;
    int n_pass;

    // Behavioural model state.
    int m_mode;
    int m_left;
    int m_waited;
    int m_locked_for;
    int m_timeouts;
    int m_losses;
    bit m_h1;
    bit m_h2;

    typedef struct packed {
        int         edge_no;
        logic       lock_after;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .CNT_W          (CNT_W)
    ) dut (
        .i_refclk        (clk),
        .i_rst_n         (rst_n),
        .i_pll_locked    (pll_locked),
        .o_pll_rst       (pll_rst),
        .o_sys_rst_n     (sys_rst_n),
        .o_ready         (ready),
        .o_lock_loss_cnt (lock_loss_cnt),
        .o_fault         (fault)
    );

    function automatic logic [5:0] pack_exp(input bit pr, input bit sr, input bit rd,
                                            input bit ft, input int llc);
        return {pr, sr, rd, ft, CNT_W'(llc)};
    endfunction

    function automatic logic [5:0] dut_out();
        return {pll_rst, sys_rst_n, ready, fault, lock_loss_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [5:0] exp);
        n_checks++;
        if (dut_out() === exp) n_pass++;
        else $display("FAIL %s edge %0d: got {rst,srn,rdy,flt,llc}=%b expected %b",
                      name, edge_n, dut_out(), exp);
    endtask

    task automatic advance_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        @(posedge clk);
        edge_n = 0;
        @(negedge clk);
        check_vec("reset_vals", pack_exp(1, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input logic val, input int limit, input string name,
                              output bit saw_prst);
        int n;
        n        = 0;
        saw_prst = 1'b0;
        while (ready !== val && n < limit) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            n++;
            if (pll_rst) saw_prst = 1'b1;
        end
        check(name, 32'(ready), 32'(val));
    endtask

    function automatic void model_reset();
        m_mode       = MD_PULSE;
        m_left       = PLL_RST_CYCLES;
        m_waited     = 0;
        m_locked_for = 0;
        m_timeouts   = 0;
        m_losses     = 0;
        m_h1         = 1'b0;
        m_h2         = 1'b0;
    endfunction

    // One refclk edge: the sequencer reacts to pll_locked as it was two edges earlier.
    function automatic void model_step();
        bit seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = m_h2;
        m_h2 = m_h1;
        m_h1 = pll_locked;
        case (m_mode)
            MD_PULSE: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode   = MD_WAIT;
                    m_waited = 0;
                end
            end
            MD_WAIT: begin
                if (seen) begin
                    m_mode       = MD_STABLE;
                    m_locked_for = 0;
                end else begin
                    m_waited++;
                    if (m_waited == LOCK_TIMEOUT) begin
                        m_timeouts++;
                        m_mode = MD_PULSE;
                        m_left = PLL_RST_CYCLES;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        if (m_timeouts == MAX_RETRIES) m_mode = MD_FAIL;
`endif
                    end
                end
            end
            MD_STABLE: begin
                if (!seen) begin
                    m_mode   = MD_WAIT;
                    m_waited = 0;
                end else begin
                    m_locked_for++;
                    if (m_locked_for == STABLE_CYCLES) begin
                        m_mode     = MD_RUN;
                        m_timeouts = 0;
                    end
                end
            end
            MD_RUN: begin
                if (!seen) begin
                    m_mode   = MD_WAIT;
                    m_waited = 0;
                    if (m_losses < LOSS_SAT) m_losses++;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [5:0] model_exp();
        return pack_exp(m_mode == MD_PULSE || m_mode == MD_FAIL, m_mode == MD_RUN,
                        m_mode == MD_RUN, m_mode == MD_FAIL, m_losses);
    endfunction

    task automatic add_vec(input int e, input bit lk, input bit pr, input bit sr,
                           input bit rd, input int llc);
        vecs.push_back(vec_t'{edge_no: e, lock_after: lk, exp: pack_exp(pr, sr, rd, 0, llc)});
    endtask

    initial begin
        bit saw;
        int run_left;
        n_checks   = 0;
        n_pass     = 0;
        edge_n     = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;

        // Bring-up, then loss in RUN and relock: {edge, lock after edge, pll_rst, srn, rdy, llc}
        add_vec(1,  0, 1, 0, 0, 0);
        add_vec(3,  0, 1, 0, 0, 0);
        add_vec(4,  0, 0, 0, 0, 0);
        add_vec(9,  1, 0, 0, 0, 0);
        add_vec(19, 1, 0, 0, 0, 0);
        add_vec(20, 1, 0, 1, 1, 0);
        add_vec(24, 0, 0, 1, 1, 0);
        add_vec(26, 0, 0, 1, 1, 0);
        add_vec(27, 1, 0, 0, 0, 1);
        add_vec(30, 1, 0, 0, 0, 1);
        add_vec(37, 1, 0, 0, 0, 1);
        add_vec(38, 1, 0, 1, 1, 1);

        do_reset();
        foreach (vecs[i]) begin
            advance_to(vecs[i].edge_no);
            check_vec($sformatf("vec%0d_e%0d", i, vecs[i].edge_no), vecs[i].exp);
            pll_locked = vecs[i].lock_after;
        end

        // One-cycle lock glitch during STABLE restarts the stability count.
        do_reset();
        advance_to(9);
        pll_locked = 1'b1;
        advance_to(14);
        pll_locked = 1'b0;
        advance_to(15);
        pll_locked = 1'b1;
        advance_to(20);
        check_vec("glitch_e20", pack_exp(0, 0, 0, 0, 0));
        advance_to(25);
        check_vec("glitch_e25", pack_exp(0, 0, 0, 0, 0));
        advance_to(26);
        check_vec("glitch_e26", pack_exp(0, 1, 1, 0, 0));

        // Lock seen on the very cycle the timeout expires: lock wins.
        do_reset();
        advance_to(33);
        check_vec("tie_e33", pack_exp(0, 0, 0, 0, 0));
        pll_locked = 1'b1;
        advance_to(36);
        check_vec("tie_e36", pack_exp(0, 0, 0, 0, 0));
        advance_to(43);
        check_vec("tie_e43", pack_exp(0, 0, 0, 0, 0));
        advance_to(44);
        check_vec("tie_e44", pack_exp(0, 1, 1, 0, 0));

        // No lock: re-pulse every 36 cycles, or FAIL after the second timeout.
        do_reset();
        advance_to(35);
        check_vec("nolock_e35", pack_exp(0, 0, 0, 0, 0));
        advance_to(36);
        check_vec("nolock_e36", pack_exp(1, 0, 0, 0, 0));
        advance_to(39);
        check_vec("nolock_e39", pack_exp(1, 0, 0, 0, 0));
        advance_to(40);
        check_vec("nolock_e40", pack_exp(0, 0, 0, 0, 0));
        advance_to(71);
        check_vec("nolock_e71", pack_exp(0, 0, 0, 0, 0));
        advance_to(72);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        check_vec("nolock_e72", pack_exp(1, 0, 0, 1, 0));
        advance_to(76);
        check_vec("nolock_e76", pack_exp(1, 0, 0, 1, 0));
        pll_locked = 1'b1;
        advance_to(100);
        check_vec("nolock_e100", pack_exp(1, 0, 0, 1, 0));
`else
        check_vec("nolock_e72", pack_exp(1, 0, 0, 0, 0));
        advance_to(76);
        check_vec("nolock_e76", pack_exp(0, 0, 0, 0, 0));
        pll_locked = 1'b1;
        advance_to(100);
        check_vec("nolock_e100", pack_exp(0, 1, 1, 0, 0));
`endif

        // Five loss/relock cycles: counter saturates, PLL never re-pulsed.
        do_reset();
        pll_locked = 1'b1;
        wait_ready(1'b1, 40, "sat_bringup", saw);
        for (int k = 1; k <= 5; k++) begin
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, $sformatf("sat_drop%0d", k), saw);
            check($sformatf("sat_cnt%0d", k), 32'(lock_loss_cnt),
                  32'((k < LOSS_SAT) ? k : LOSS_SAT));
            pll_locked = 1'b1;
            wait_ready(1'b1, 30, $sformatf("sat_relock%0d", k), saw);
            check($sformatf("sat_no_pll_rst%0d", k), 32'(saw), 32'd0);
        end

        // Asynchronous reset in STABLE clears everything without a clock edge.
        pll_locked = 1'b0;
        wait_ready(1'b0, 10, "mid_drop", saw);
        pll_locked = 1'b1;
        advance_to(edge_n + 5);
        check_vec("mid_in_stable", pack_exp(0, 0, 0, 0, LOSS_SAT));
        rst_n = 1'b0;
        #1;
        check_vec("mid_async_rst", pack_exp(1, 0, 0, 0, 0));
        @(posedge clk);
        edge_n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        advance_to(3);
        check_vec("mid_rel_e3", pack_exp(1, 0, 0, 0, 0));
        advance_to(4);
        check_vec("mid_rel_e4", pack_exp(0, 0, 0, 0, 0));
        advance_to(12);
        check_vec("mid_rel_e12", pack_exp(0, 0, 0, 0, 0));
        advance_to(13);
        check_vec("mid_rel_e13", pack_exp(0, 1, 1, 0, 0));

        // Random lock activity and occasional resets against the model.
        do_reset();
        model_reset();
        pll_locked = 1'b1;
        run_left   = 32'($urandom_range(1, 60));
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            model_step();
            check_vec("rand", model_exp());
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_vec("rand_async_rst", model_exp());
            end
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                run_left   = pll_locked ? 32'($urandom_range(1, 60)) : 32'($urandom_range(1, 80));
            end else begin
                run_left--;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Companion controller on the other end of the 25 MHz pixel-clock PLL's reset/locked interface.
- Runs on the 50 MHz reference clock and drives the PLL reset.
- Watches the asynchronous locked output and releases the downstream system reset only after lock has been stable for a programmed time.
- Re-sequences automatically on lock timeout or loss of lock; sits between the board reset button, the PLL, and the game/VGA logic.

Parameters:
- PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset pulse (min 1).
- LOCK_TIMEOUT, 50000, refclk cycles to wait for lock before re-pulsing pll_rst (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before releasing sys_rst_n.
- MAX_RETRIES, 4, timeouts tolerated before FAIL (used only with the optional feature).
- CNT_W, 8, width of lock_loss_cnt.

Ports:
- refclk  in  1  50 MHz reference clock; same net as the PLL refclk.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked; asynchronous to refclk.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low reset to downstream logic, registered.
- ready  out  1  high while in RUN.
- lock_loss_cnt  out  CNT_W  saturating count of lock losses seen in RUN.
- fault  out  1  high in FAIL (tied 0 without the optional feature).

Behaviour:
- Reset values (rst_n low, asynchronous): state=PLL_RESET, pll_rst=1, sys_rst_n=0, ready=0, lock_loss_cnt=0, fault=0, all internal counters 0, synchronizer flops 0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). Only locked_s is used by the FSM.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- Counter widths are $clog2 of the largest cycle parameter + 1. A single shared cycle counter clears on every state change.
- PLL_RESET: pll_rst=1.
  - After exactly PLL_RST_CYCLES cycles, go to WAIT_LOCK; pll_rst=0 from that edge.
  - With rst_n released at edge 0, pll_rst is low from edge PLL_RST_CYCLES.
- WAIT_LOCK: pll_rst=0.
  - locked_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT with locked_s=0: go to PLL_RESET and increment retry_cnt.
  - If locked_s=1 in the same cycle as the timeout, lock wins.
- STABLE: counts consecutive locked_s=1 cycles.
  - locked_s=0 at any point: return to WAIT_LOCK with the counter cleared; no retry increment.
  - Count reaches STABLE_CYCLES: go to RUN. sys_rst_n=1 and ready=1 from that edge, i.e. STABLE_CYCLES edges after locked_s first rose.
- RUN: sys_rst_n=1, ready=1.
  - locked_s=0: go to WAIT_LOCK; sys_rst_n=0 and ready=0 on that edge.
  - lock_loss_cnt increments, saturating at 2^CNT_W-1.
  - pll_rst is not pulsed; the PLL reacquires on its own.
- retry_cnt clears on entry to RUN.
- lock_loss_cnt clears only on rst_n.
- rst_n asserted mid-operation: immediate return to reset values; full sequence restarts on release.

Optional Feature:
- Macro PLL_SEQ_RETRY_LIMIT_EN.
- Defined: the WAIT_LOCK timeout that would make retry_cnt reach MAX_RETRIES enters FAIL instead of PLL_RESET.
  - FAIL holds pll_rst=1, sys_rst_n=0, ready=0, fault=1 until rst_n.
  - FAIL ignores locked_s.
- Undefined: no FAIL state, retries continue forever, fault is driven constant 0, retry_cnt is not implemented.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum: PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL;
  - default cycle constants for 50 MHz (PLL_RST_CYCLES_50M, LOCK_TIMEOUT_1MS_50M, STABLE_1K).
- One natural sub-module, sync_2ff: a generic 2-flop synchronizer with active-low asynchronous reset to 0, instantiated for pll_locked and reused elsewhere.

Test Plan (bench params PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2):
- Normal bring-up: rst_n released at edge 0, pll_locked raised before edge 10 -> pll_rst high edges 0-3 and low from 4; locked_s high at 12; sys_rst_n=1, ready=1 at edge 20.
- Glitch: as above, pll_locked low for one cycle before edge 15 -> FSM returns to WAIT_LOCK; sys_rst_n stays 0 until 8 edges after locked_s recovers; retry count unchanged.
- No lock: pll_locked held 0 -> pll_rst re-pulses 4 cycles every 36.
  - With the macro: FAIL and fault=1 after the 2nd timeout; later pll_locked=1 has no effect.
  - Without the macro: pulses continue, fault=0.
- Loss in RUN: drop pll_locked while ready=1 -> sys_rst_n=0 three edges after the raw drop, lock_loss_cnt=1; relock -> release after 8 stable cycles with no pll_rst pulse.
- Saturation: five loss/relock cycles -> lock_loss_cnt=3.
- Mid-sequence reset: assert rst_n low during STABLE -> pll_rst=1, sys_rst_n=0, ready=0 and lock_loss_cnt=0 immediately without a clock edge; release -> full 4-cycle PLL_RESET repeats.
